// File: rtl/tl_master_arbiter.sv
// Shares one TileLink-UL master port between N_REQ requesters: round-robin A arbitration with
// locked Put bursts, source tagging, and D steering. Optional macro: TL_ARB_OUTST_LIMIT_EN.
module tl_master_arbiter #(
  parameter  int unsigned N_REQ     = 2,
  parameter  int unsigned REQ_SRC_W = 1,
  parameter  int unsigned MAX_OUTST = 2,
  localparam int unsigned IDX_W     = $clog2(N_REQ),
  localparam int unsigned OUT_SRC_W = IDX_W + REQ_SRC_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              r_a_valid,
  output logic [N_REQ-1:0]              r_a_ready,
  input  logic [3*N_REQ-1:0]            r_a_opcode,
  input  logic [4*N_REQ-1:0]            r_a_size,
  input  logic [REQ_SRC_W*N_REQ-1:0]    r_a_source,
  input  logic [32*N_REQ-1:0]           r_a_address,
  input  logic [8*N_REQ-1:0]            r_a_mask,
  input  logic [64*N_REQ-1:0]           r_a_data,
  output logic                          m_a_valid,
  input  logic                          m_a_ready,
  output logic [2:0]                    m_a_opcode,
  output logic [3:0]                    m_a_size,
  output logic [OUT_SRC_W-1:0]          m_a_source,
  output logic [31:0]                   m_a_address,
  output logic [7:0]                    m_a_mask,
  output logic [63:0]                   m_a_data,
  input  logic                          m_d_valid,
  output logic                          m_d_ready,
  input  logic [2:0]                    m_d_opcode,
  input  logic [3:0]                    m_d_size,
  input  logic [OUT_SRC_W-1:0]          m_d_source,
  input  logic [63:0]                   m_d_data,
  input  logic                          m_d_error,
  output logic [N_REQ-1:0]              r_d_valid,
  input  logic [N_REQ-1:0]              r_d_ready,
  output logic [2:0]                    r_d_opcode,
  output logic [3:0]                    r_d_size,
  output logic [REQ_SRC_W-1:0]          r_d_source,
  output logic [63:0]                   r_d_data,
  output logic                          r_d_error
);

  localparam int unsigned CNT_W = 13;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   lock_idx;
  logic [CNT_W-1:0]   beat_cnt;

  logic [N_REQ-1:0]   limit_ok;
  logic [N_REQ-1:0]   eligible;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   pick;
  logic               pick_ok;
  logic [IDX_W-1:0]   grant;
  int unsigned        g_ofs;
  logic               a_hs;
  logic               multi;
  logic [CNT_W-1:0]   burst_last;
  logic [IDX_W-1:0]   tgt;

  assign eligible = r_a_valid & limit_ok;

  always_comb begin
    scan_idx = '0;
    pick     = rr_ptr;
    pick_ok  = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = rr_ptr + IDX_W'(k);
      if (!pick_ok && eligible[scan_idx]) begin
        pick    = scan_idx;
        pick_ok = 1'b1;
      end
    end
  end

  // A locked burst bypasses the round-robin scan and the outstanding limit.
  assign grant     = (state == LOCKED) ? lock_idx : pick;
  assign m_a_valid = !reset && ((state == LOCKED) ? r_a_valid[lock_idx] : pick_ok);
  assign a_hs      = m_a_valid && m_a_ready;

  always_comb begin
    r_a_ready = '0;
    if (a_hs) r_a_ready[grant] = 1'b1;
  end

  assign g_ofs       = 32'(grant);
  assign m_a_opcode  = r_a_opcode[g_ofs*3 +: 3];
  assign m_a_size    = r_a_size[g_ofs*4 +: 4];
  assign m_a_source  = {grant, r_a_source[g_ofs*REQ_SRC_W +: REQ_SRC_W]};
  assign m_a_address = r_a_address[g_ofs*32 +: 32];
  assign m_a_mask    = r_a_mask[g_ofs*8 +: 8];
  assign m_a_data    = r_a_data[g_ofs*64 +: 64];

  assign multi      = (m_a_opcode == 3'd0 || m_a_opcode == 3'd1) && (m_a_size > 4'd3);
  assign burst_last = (CNT_W'(1) << (m_a_size - 4'd3)) - CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_hs) begin
            if (multi) begin
              beat_cnt <= burst_last;
              lock_idx <= grant;
              state    <= LOCKED;
            end else begin
              rr_ptr <= grant + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (a_hs) begin
            beat_cnt <= beat_cnt - 1'b1;
            if (beat_cnt == CNT_W'(1)) begin
              rr_ptr <= lock_idx + 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tgt = m_d_source[OUT_SRC_W-1 -: IDX_W];

  always_comb begin
    r_d_valid = '0;
    if (!reset) r_d_valid[tgt] = m_d_valid;
  end

  assign m_d_ready  = !reset && r_d_ready[tgt];
  assign r_d_opcode = m_d_opcode;
  assign r_d_size   = m_d_size;
  assign r_d_source = m_d_source[REQ_SRC_W-1:0];
  assign r_d_data   = m_d_data;
  assign r_d_error  = m_d_error;

`ifdef TL_ARB_OUTST_LIMIT_EN
  localparam int unsigned OUTST_W = $clog2(MAX_OUTST + 1);

  logic [OUTST_W-1:0] outst [N_REQ];
  logic [CNT_W-1:0]   d_cnt;
  logic [CNT_W-1:0]   d_beats_m1;
  logic               d_hs;
  logic               d_is_data;
  logic               d_last;

  assign d_hs       = m_d_valid && m_d_ready;
  assign d_is_data  = (m_d_opcode == 3'd1);
  assign d_beats_m1 = (m_d_size > 4'd3) ? (CNT_W'(1) << (m_d_size - 4'd3)) - CNT_W'(1) : '0;
  assign d_last     = !d_is_data || (d_cnt == d_beats_m1);

  // D beats of one message are contiguous, so one shared beat counter suffices.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_cnt <= '0;
    end else if (d_hs && d_is_data) begin
      d_cnt <= d_last ? '0 : d_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (reset) begin
        outst[i] <= '0;
      end else begin
        if ((a_hs && state == IDLE && grant == IDX_W'(i)) && !(d_hs && d_last && tgt == IDX_W'(i)))
          outst[i] <= outst[i] + 1'b1;
        else if (!(a_hs && state == IDLE && grant == IDX_W'(i)) && (d_hs && d_last && tgt == IDX_W'(i)))
          outst[i] <= outst[i] - 1'b1;
      end
    end
  end

  always_comb begin
    limit_ok = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      limit_ok[i] = (outst[i] != OUTST_W'(MAX_OUTST));
  end
`else
  logic unused_max_outst;
  assign unused_max_outst = (MAX_OUTST == 0);
  assign limit_ok = '1;
`endif

endmodule

// File: tb/tb_tl_master_arbiter.sv
// Bench for tl_master_arbiter: per-cycle behavioural model compare plus directed literal checks.
module tb_tl_master_arbiter;
  localparam int N    = 2;
  localparam int RS   = 1;
  localparam int MAXO = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      r_a_valid;
  logic [N-1:0]      r_a_ready;
  logic [3*N-1:0]    r_a_opcode;
  logic [4*N-1:0]    r_a_size;
  logic [RS*N-1:0]   r_a_source;
  logic [32*N-1:0]   r_a_address;
  logic [8*N-1:0]    r_a_mask;
  logic [64*N-1:0]   r_a_data;
  logic              m_a_valid, m_a_ready;
  logic [2:0]        m_a_opcode;
  logic [3:0]        m_a_size;
  logic [1:0]        m_a_source;
  logic [31:0]       m_a_address;
  logic [7:0]        m_a_mask;
  logic [63:0]       m_a_data;
  logic              m_d_valid, m_d_ready;
  logic [2:0]        m_d_opcode;
  logic [3:0]        m_d_size;
  logic [1:0]        m_d_source;
  logic [63:0]       m_d_data;
  logic              m_d_error;
  logic [N-1:0]      r_d_valid, r_d_ready;
  logic [2:0]        r_d_opcode;
  logic [3:0]        r_d_size;
  logic [RS-1:0]     r_d_source;
  logic [63:0]       r_d_data;
  logic              r_d_error;

  tl_master_arbiter #(.N_REQ(N), .REQ_SRC_W(RS), .MAX_OUTST(MAXO)) dut (
    .clock(clock), .reset(reset),
    .r_a_valid(r_a_valid), .r_a_ready(r_a_ready), .r_a_opcode(r_a_opcode), .r_a_size(r_a_size),
    .r_a_source(r_a_source), .r_a_address(r_a_address), .r_a_mask(r_a_mask), .r_a_data(r_a_data),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode), .m_a_size(m_a_size),
    .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode), .m_d_size(m_d_size),
    .m_d_source(m_d_source), .m_d_data(m_d_data), .m_d_error(m_d_error),
    .r_d_valid(r_d_valid), .r_d_ready(r_d_ready), .r_d_opcode(r_d_opcode), .r_d_size(r_d_size),
    .r_d_source(r_d_source), .r_d_data(r_d_data), .r_d_error(r_d_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  bit         req_v   [N];
  logic [2:0] req_op  [N];
  logic [3:0] req_sz  [N];
  logic       req_src [N];

  int mdl_rr, mdl_owner, mdl_left, d_seen;
  bit mdl_locked;
  int outst_m [N];
  logic [1:0] hs_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic bit room(input int i);
`ifdef TL_ARB_OUTST_LIMIT_EN
    return outst_m[i] < MAXO;
`else
    return i >= 0;
`endif
  endfunction

  task automatic set_req(input int i, input bit v, input logic [2:0] op, input logic [3:0] sz,
                         input logic src);
    req_v[i] = v; req_op[i] = op; req_sz[i] = sz; req_src[i] = src;
    r_a_valid[i]          = v;
    r_a_opcode[i*3 +: 3]  = op;
    r_a_size[i*4 +: 4]    = sz;
    r_a_source[i]         = src;
    r_a_address[i*32 +: 32] = addr_of(i);
    r_a_mask[i*8 +: 8]    = 8'hF0 | 8'(i);
    r_a_data[i*64 +: 64]  = 64'hA5A5_0000_0000_0000 | 64'(i);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected grant order packed MSB-first, two bits per handshake.
  task automatic check_hs(input string name, input int n, input logic [15:0] seq);
    logic [1:0] act;
    check({name, "_count"}, hs_q.size(), n);
    for (int k = 0; k < n; k++) begin
      act = (k < hs_q.size()) ? hs_q[k] : 2'bxx;
      check({name, "_grant"}, act, seq[2*(n-1-k) +: 2]);
    end
  endtask

  always @(negedge clock) begin
    int g, idx, tgt, beats, dbeats;
    bit v, last;
    logic [N-1:0] e_rdy, e_rdv;
    logic e_mdr;
    g = 0; v = 1'b0; idx = 0;
    if (m_a_valid === 1'b1 && m_a_ready === 1'b1) hs_q.push_back(m_a_source);
    if (reset) begin
      check("rst_m_a_valid", m_a_valid, 0);
      check("rst_r_a_ready", r_a_ready, 0);
      check("rst_r_d_valid", r_d_valid, 0);
      check("rst_m_d_ready", m_d_ready, 0);
      mdl_rr = 0; mdl_locked = 1'b0; mdl_left = 0; d_seen = 0;
      for (int i = 0; i < N; i++) outst_m[i] = 0;
    end else begin
      if (mdl_locked) begin
        g = mdl_owner; v = req_v[g];
      end else begin
        for (int k = 0; k < N; k++) begin
          idx = (mdl_rr + k) % N;
          if (!v && req_v[idx] && room(idx)) begin g = idx; v = 1'b1; end
        end
      end
      e_rdy = (v && m_a_ready) ? N'(1 << g) : '0;
      check("m_a_valid", m_a_valid, v);
      check("r_a_ready", r_a_ready, e_rdy);
      if (v) begin
        check("m_a_source", m_a_source, (g << RS) | int'(req_src[g]));
        check("m_a_opcode", m_a_opcode, req_op[g]);
        check("m_a_size", m_a_size, req_sz[g]);
        check("m_a_address", m_a_address, addr_of(g));
        check("m_a_mask", m_a_mask, 8'hF0 | 8'(g));
        check("m_a_data", m_a_data, 64'hA5A5_0000_0000_0000 | 64'(g));
      end
      tgt   = int'(m_d_source) >> RS;
      e_rdv = m_d_valid ? N'(1 << tgt) : '0;
      e_mdr = r_d_ready[tgt];
      check("r_d_valid", r_d_valid, e_rdv);
      check("m_d_ready", m_d_ready, e_mdr);
      if (m_d_valid) begin
        check("r_d_source", r_d_source, int'(m_d_source) % (1 << RS));
        check("r_d_data", r_d_data, m_d_data);
        check("r_d_opcode", r_d_opcode, m_d_opcode);
        check("r_d_error", r_d_error, m_d_error);
      end
      if (v && m_a_ready) begin
        if (mdl_locked) begin
          mdl_left--;
          if (mdl_left == 0) begin mdl_locked = 1'b0; mdl_rr = (mdl_owner + 1) % N; end
        end else begin
          beats = (req_op[g] <= 3'd1 && req_sz[g] > 4'd3) ? (1 << (int'(req_sz[g]) - 3)) : 1;
          outst_m[g]++;
          if (beats > 1) begin mdl_locked = 1'b1; mdl_owner = g; mdl_left = beats - 1; end
          else mdl_rr = (g + 1) % N;
        end
      end
      if (m_d_valid && e_mdr) begin
        last = 1'b1;
        if (m_d_opcode == 3'd1) begin
          dbeats = (m_d_size > 4'd3) ? (1 << (int'(m_d_size) - 3)) : 1;
          d_seen++;
          last = (d_seen == dbeats);
          if (last) d_seen = 0;
        end
        if (last && outst_m[tgt] > 0) outst_m[tgt]--;
      end
    end
  end

  initial begin
    r_a_valid = '0; r_a_opcode = '0; r_a_size = '0; r_a_source = '0;
    r_a_address = '0; r_a_mask = '0; r_a_data = '0;
    m_a_ready = 1'b1;
    m_d_valid = 1'b1; m_d_opcode = 3'd0; m_d_size = 4'd3; m_d_source = 2'b10;
    m_d_data = 64'h1234_5678; m_d_error = 1'b0; r_d_ready = 2'b11;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'd4, 4'd3, 1'b0);
    set_req(0, 1'b1, 3'd4, 4'd3, 1'b1);
    step(); step();
    #1;
    check("lit_rst_m_a_valid", m_a_valid, 0);
    check("lit_rst_m_d_ready", m_d_ready, 0);

    // 1: alternating grants between two Get streams
    step();
    m_d_valid = 1'b0;
    reset = 1'b0;
    hs_q.delete();
    repeat (4) step();
    set_req(0, 1'b0, 3'd4, 4'd3, 1'b1);
    set_req(1, 1'b0, 3'd4, 4'd3, 1'b0);
    check_hs("t1_rr", 4, 16'b01_10_01_10);

    // 2: four-beat PutFull from r0 locks out r1
    set_req(0, 1'b1, 3'd0, 4'd5, 1'b0);
    set_req(1, 1'b1, 3'd4, 4'd3, 1'b1);
    hs_q.delete();
    step();
    #1;
    check("lit_t2_lock_src", m_a_source, 2'b00);
    check("lit_t2_lock_rdy", r_a_ready, 2'b01);
    repeat (3) step();
    set_req(0, 1'b0, 3'd0, 4'd5, 1'b0);
    step();
    set_req(1, 1'b0, 3'd4, 4'd3, 1'b1);
    step();
    check_hs("t2_burst", 5, 16'b00_00_00_00_11);

    // 3: backpressure at beat 2 holds the lock
    set_req(0, 1'b1, 3'd0, 4'd5, 1'b0);
    set_req(1, 1'b1, 3'd4, 4'd3, 1'b1);
    hs_q.delete();
    step();
    m_a_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lit_t3_stall_valid", m_a_valid, 1);
      check("lit_t3_stall_src", m_a_source, 2'b00);
      check("lit_t3_stall_rdy", r_a_ready, 2'b00);
      step();
    end
    m_a_ready = 1'b1;
    repeat (3) step();
    set_req(0, 1'b0, 3'd0, 4'd5, 1'b0);
    step();
    set_req(1, 1'b0, 3'd4, 4'd3, 1'b1);
    step();
    check_hs("t3_stall", 5, 16'b00_00_00_00_11);

    // 4: D steering with backpressure, alongside an A handshake
    hs_q.delete();
    set_req(1, 1'b1, 3'd4, 4'd3, 1'b1);
    m_d_valid = 1'b1; m_d_opcode = 3'd1; m_d_size = 4'd4; m_d_source = 2'b10;
    m_d_data = 64'hDEAD_BEEF_0000_0001; r_d_ready = 2'b10;
    #1;
    check("lit_t4_rdv", r_d_valid, 2'b10);
    check("lit_t4_mdr", m_d_ready, 1);
    check("lit_t4_rds", r_d_source, 0);
    step();
    set_req(1, 1'b0, 3'd4, 4'd3, 1'b1);
    r_d_ready = 2'b01; m_d_data = 64'hDEAD_BEEF_0000_0002;
    #1;
    check("lit_t4_bp_mdr", m_d_ready, 0);
    check("lit_t4_bp_rdv", r_d_valid, 2'b10);
    step();
    r_d_ready = 2'b10;
    step();
    m_d_opcode = 3'd0; m_d_size = 4'd3; m_d_source = 2'b01; r_d_ready = 2'b01;
    #1;
    check("lit_t4_r0_rdv", r_d_valid, 2'b01);
    check("lit_t4_r0_rds", r_d_source, 1);
    step();
    m_d_valid = 1'b0;
    check_hs("t4_ad", 1, 16'b11);

    // 6: reset mid-burst clears lock and rr_ptr
    set_req(0, 1'b1, 3'd4, 4'd3, 1'b1);
    step();
    set_req(0, 1'b0, 3'd4, 4'd3, 1'b1);
    set_req(1, 1'b1, 3'd0, 4'd5, 1'b0);
    step();
    step();
    reset = 1'b1;
    set_req(1, 1'b0, 3'd0, 4'd5, 1'b0);
    #1;
    check("lit_t6_rst_valid", m_a_valid, 0);
    step();
    reset = 1'b0;
    hs_q.delete();
    set_req(0, 1'b1, 3'd4, 4'd3, 1'b1);
    set_req(1, 1'b1, 3'd4, 4'd3, 1'b0);
    #1;
    check("lit_t6_post_valid", m_a_valid, 1);
    check("lit_t6_post_src", m_a_source, 2'b01);
    step();
    set_req(0, 1'b0, 3'd4, 4'd3, 1'b1);
    set_req(1, 1'b0, 3'd4, 4'd3, 1'b0);
    step();
    check_hs("t6_reset", 1, 16'b01);

`ifdef TL_ARB_OUTST_LIMIT_EN
    // 5: outstanding limit excludes r0 until a response returns
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 1'b1, 3'd4, 4'd3, 1'b0);
    step();
    step();
    set_req(1, 1'b1, 3'd4, 4'd3, 1'b1);
    #1;
    check("lit_t5_r1_src", m_a_source, 2'b11);
    check("lit_t5_r1_rdy", r_a_ready, 2'b10);
    step();
    set_req(1, 1'b0, 3'd4, 4'd3, 1'b1);
    m_d_valid = 1'b1; m_d_opcode = 3'd0; m_d_size = 4'd3; m_d_source = 2'b00; r_d_ready = 2'b01;
    #1;
    check("lit_t5_r0_blocked", m_a_valid, 0);
    step();
    m_d_valid = 1'b0;
    #1;
    check("lit_t5_r0_valid", m_a_valid, 1);
    check("lit_t5_r0_src", m_a_source, 2'b00);
    step();
    set_req(0, 1'b0, 3'd4, 4'd3, 1'b0);
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
